// File: rtl/fft_reorder_ctrl.sv
// Ping-pong reorder buffer: bit-reversed FFT output in, natural-order frames out.
// Optional `FFT_REORDER_DROP_CNT_EN adds a saturating count of refused input samples.
module fft_reorder_ctrl #(
    parameter int DATA_W = 17
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic                     in_sop,
    input  logic signed [DATA_W-1:0] in_r,
    input  logic signed [DATA_W-1:0] in_i,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic                     out_sop,
    output logic                     out_eop,
    output logic signed [DATA_W-1:0] out_r,
    output logic signed [DATA_W-1:0] out_i,
    input  logic                     out_ready,
    output logic                     frame_err
`ifdef FFT_REORDER_DROP_CNT_EN
    ,
    output logic [7:0]               drop_cnt
`endif
);

    function automatic logic [4:0] bitrev5(input logic [4:0] a);
        return {a[0], a[1], a[2], a[3], a[4]};
    endfunction

    // Both banks share one array; the top address bit selects the bank.
    logic signed [DATA_W-1:0] bank_r [64];
    logic signed [DATA_W-1:0] bank_i [64];

    logic [1:0] full;
    logic       wb;
    logic       rb;
    logic [4:0] wcnt;
    logic [4:0] rcnt;

    logic       accept;
    logic       wr_en;
    logic       take;
    logic [4:0] waddr;

    assign in_ready  = !full[wb];
    assign out_valid = full[rb];

    always_comb begin
        accept = in_valid && in_ready;
        // A non-SOP sample only counts once a frame has been opened by SOP.
        wr_en  = accept && (in_sop || (wcnt != '0));
        waddr  = in_sop ? '0 : bitrev5(wcnt);
        take   = out_valid && out_ready;
    end

    always_ff @(posedge clk) begin
        if (!rst_n && wr_en) begin
            bank_r[{wb, waddr}] <= in_r;
            bank_i[{wb, waddr}] <= in_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            full      <= '0;
            wb        <= 1'b0;
            rb        <= 1'b0;
            wcnt      <= '0;
            rcnt      <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= accept && in_sop && (wcnt != '0);
            if (wr_en) begin
                if (in_sop) begin
                    wcnt <= 5'd1;
                end else if (wcnt == 5'd31) begin
                    full[wb] <= 1'b1;
                    wb       <= ~wb;
                    wcnt     <= '0;
                end else begin
                    wcnt <= wcnt + 5'd1;
                end
            end
            // Fill needs !full[wb] and drain needs full[rb], so they never hit the same flag.
            if (take) begin
                if (rcnt == 5'd31) begin
                    full[rb] <= 1'b0;
                    rb       <= ~rb;
                    rcnt     <= '0;
                end else begin
                    rcnt <= rcnt + 5'd1;
                end
            end
        end
    end

    always_comb begin
        out_r   = '0;
        out_i   = '0;
        out_sop = 1'b0;
        out_eop = 1'b0;
        if (out_valid) begin
            out_r   = bank_r[{rb, rcnt}];
            out_i   = bank_i[{rb, rcnt}];
            out_sop = (rcnt == 5'd0);
            out_eop = (rcnt == 5'd31);
        end
    end

`ifdef FFT_REORDER_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (rst_n) begin
            drop_cnt <= '0;
        end else if (in_valid && !in_ready && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fft_reorder_ctrl.sv
// Directed bench for fft_reorder_ctrl: address-mapping table plus multi-cycle frame sequences.
module tb_fft_reorder_ctrl;

    localparam int W = 17;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                in_valid;
    logic                in_sop;
    logic signed [W-1:0] in_r;
    logic signed [W-1:0] in_i;
    logic                in_ready;
    logic                out_valid;
    logic                out_sop;
    logic                out_eop;
    logic signed [W-1:0] out_r;
    logic signed [W-1:0] out_i;
    logic                out_ready;
    logic                frame_err;
`ifdef FFT_REORDER_DROP_CNT_EN
    logic [7:0]          drop_cnt;
`endif

    fft_reorder_ctrl #(.DATA_W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_sop    (in_sop),
        .in_r      (in_r),
        .in_i      (in_i),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .out_r     (out_r),
        .out_i     (out_i),
        .out_ready (out_ready),
        .frame_err (frame_err)
`ifdef FFT_REORDER_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int k;
        int addr;
    } map_vec_t;

    map_vec_t vecs[12];
    int       cap_r[32];
    int       checks = 0;
    int       errors = 0;
    int       ferr_cnt;
    int       ferr_first;
    int       drops;
    int       valid_before_last;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, summary not reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int brev(input int j);
        int r = 0;
        for (int b = 0; b < 5; b++)
            if (j[b]) r = r | (1 << (4 - b));
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_sop    = 1'b0;
        out_ready = 1'b0;
        step();
        rst_n = 1'b0;
    endtask

    // raw=0: slot j carries tag*32+bitrev(j), so natural index n reads back tag*32+n.
    task automatic send_samples(input int tag, input int n, input bit sop_first, input bit raw);
        int v;
        ferr_cnt = 0;
        ferr_first = 0;
        for (int j = 0; j < n; j++) begin
            v = raw ? (100 + j) : (tag * 32 + brev(j));
            if (j == n - 1) valid_before_last = int'(out_valid);
            if (!in_ready) drops++;
            in_valid = 1'b1;
            in_sop   = sop_first && (j == 0);
            in_r     = W'(v);
            in_i     = W'(-v - 1);
            step();
            if (frame_err) ferr_cnt++;
            if (j == 0) ferr_first = int'(frame_err);
        end
        in_valid = 1'b0;
        in_sop   = 1'b0;
    endtask

    task automatic drain_frame(input int tag);
        for (int n = 0; n < 32; n++) begin
            check($sformatf("f%0d_valid_n%0d", tag, n), int'(out_valid), 1);
            check($sformatf("f%0d_r_n%0d", tag, n), int'(out_r), tag * 32 + n);
            check($sformatf("f%0d_i_n%0d", tag, n), int'(out_i), -(tag * 32 + n) - 1);
            check($sformatf("f%0d_sop_n%0d", tag, n), int'(out_sop), (n == 0) ? 1 : 0);
            check($sformatf("f%0d_eop_n%0d", tag, n), int'(out_eop), (n == 31) ? 1 : 0);
            out_ready = 1'b1;
            step();
        end
    endtask

    initial begin
        vecs[0]  = '{0, 0};
        vecs[1]  = '{1, 16};
        vecs[2]  = '{2, 8};
        vecs[3]  = '{3, 24};
        vecs[4]  = '{4, 4};
        vecs[5]  = '{5, 20};
        vecs[6]  = '{6, 12};
        vecs[7]  = '{7, 28};
        vecs[8]  = '{10, 10};
        vecs[9]  = '{17, 17};
        vecs[10] = '{30, 15};
        vecs[11] = '{31, 31};

        rst_n = 1'b1; in_valid = 1'b0; in_sop = 1'b0; in_r = '0; in_i = '0; out_ready = 1'b0;
        do_reset();
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_sop", int'(out_sop), 0);
        check("rst_out_eop", int'(out_eop), 0);
        check("rst_frame_err", int'(frame_err), 0);
        check("rst_out_r", int'(out_r), 0);
        check("rst_out_i", int'(out_i), 0);
`ifdef FFT_REORDER_DROP_CNT_EN
        check("rst_drop_cnt", int'(drop_cnt), 0);
`endif

        // Non-SOP samples after reset must not open a frame.
        send_samples(9, 5, 1'b0, 1'b0);
        check("junk_out_valid", int'(out_valid), 0);

        // Single frame, natural-order readout, 1-cycle latency.
        out_ready = 1'b1;
        send_samples(0, 32, 1'b1, 1'b0);
        check("junk_no_frame_err", ferr_cnt, 0);
        check("lat_valid_before_last", valid_before_last, 0);
        check("lat_valid", int'(out_valid), 1);
        check("lat_sop", int'(out_sop), 1);
        check("lat_r", int'(out_r), 0);
        drain_frame(0);
        check("f0_after_valid", int'(out_valid), 0);

        // Table: slot k must land at natural address bitrev5(k).
        out_ready = 1'b0;
        send_samples(0, 32, 1'b1, 1'b1);
        for (int n = 0; n < 32; n++) begin
            cap_r[n] = int'(out_r);
            out_ready = 1'b1;
            step();
        end
        for (int v = 0; v < 12; v++)
            check($sformatf("map_k%0d_addr%0d", vecs[v].k, vecs[v].addr),
                  cap_r[vecs[v].addr], 100 + vecs[v].k);

        // Three frames with no drain: third is refused, first two intact.
        do_reset();
        send_samples(1, 32, 1'b1, 1'b0);
        check("bp_ready_after_f1", int'(in_ready), 1);
        send_samples(2, 32, 1'b1, 1'b0);
        check("bp_ready_after_f2", int'(in_ready), 0);
        check("bp_valid_after_f2", int'(out_valid), 1);
        drops = 0;
        send_samples(3, 32, 1'b1, 1'b0);
        check("bp_dropped_samples", drops, 32);
        check("bp_ready_after_f3", int'(in_ready), 0);
        check("bp_head_r", int'(out_r), 32);
`ifdef FFT_REORDER_DROP_CNT_EN
        check("bp_drop_cnt", int'(drop_cnt), 32);
`endif
        drain_frame(1);
        check("bp_ready_after_drain1", int'(in_ready), 1);
        drain_frame(2);
        check("bp_valid_after_drain2", int'(out_valid), 0);
        out_ready = 1'b0;

        // Early SOP at wcnt=10 aborts the partial frame.
        do_reset();
        send_samples(4, 10, 1'b1, 1'b0);
        check("abort_partial_no_err", ferr_cnt, 0);
        check("abort_partial_no_valid", int'(out_valid), 0);
        send_samples(5, 32, 1'b1, 1'b0);
        check("abort_err_first", ferr_first, 1);
        check("abort_err_count", ferr_cnt, 1);
        drain_frame(5);
        check("abort_only_one_frame", int'(out_valid), 0);
        out_ready = 1'b0;

        // Drain with out_ready toggling 1/0: 32 transfers in 63 cycles.
        do_reset();
        send_samples(7, 32, 1'b1, 1'b0);
        begin
            int n;
            n = 0;
            for (int c = 0; c < 63; c++) begin
                check($sformatf("tog_valid_c%0d", c), int'(out_valid), 1);
                check($sformatf("tog_r_c%0d", c), int'(out_r), 7 * 32 + n);
                check($sformatf("tog_sop_c%0d", c), int'(out_sop), (n == 0) ? 1 : 0);
                check($sformatf("tog_eop_c%0d", c), int'(out_eop), (n == 31) ? 1 : 0);
                out_ready = (c % 2 == 0);
                step();
                if (c % 2 == 0) n++;
            end
        end
        check("tog_valid_end", int'(out_valid), 0);
        out_ready = 1'b0;

        // Reset in mid-drain with the other bank full.
        do_reset();
        send_samples(8, 32, 1'b1, 1'b0);
        send_samples(9, 32, 1'b1, 1'b0);
        for (int n = 0; n < 12; n++) begin
            check($sformatf("mid_r_n%0d", n), int'(out_r), 8 * 32 + n);
            out_ready = 1'b1;
            step();
        end
        rst_n = 1'b1;
        out_ready = 1'b0;
        step();
        rst_n = 1'b0;
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_ready", int'(in_ready), 1);
        check("mid_rst_out_r", int'(out_r), 0);
        send_samples(10, 32, 1'b1, 1'b0);
        check("mid_rst_no_err", ferr_cnt, 0);
        drain_frame(10);
        check("mid_rst_valid_end", int'(out_valid), 0);
        out_ready = 1'b0;

        // Fill bank 1 while draining bank 0 at full rate.
        do_reset();
        send_samples(11, 32, 1'b1, 1'b0);
        drops = 0;
        fork
            send_samples(12, 32, 1'b1, 1'b0);
            drain_frame(11);
        join
        check("pp_no_drops", drops, 0);
        drain_frame(12);
        check("pp_valid_end", int'(out_valid), 0);
        out_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_reorder_ctrl.md
FFT_REORDER_CTRL -- requirements
Module: fft_reorder_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 17, meaning the signed width of each real and imaginary sample.
REQ-002 The block SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, synchronous and active-high (asserted = 1), sampled on the rising edge of clk.
REQ-004 The block SHALL have port in_valid  input  1  input sample present this cycle.
REQ-005 The block SHALL have port in_sop  input  1  input sample is bit-reversed index 0 of a frame; qualified by in_valid.
REQ-006 The block SHALL have port in_r, in_i  input  DATA_W each  signed FFT output, bit-reversed order.
REQ-007 The block SHALL have port in_ready  output  1  write bank available; sample accepted iff in_valid && in_ready.
REQ-008 The block SHALL have port out_valid, out_sop, out_eop  output  1 each  natural-order output sample, first, last.
REQ-009 The block SHALL have port out_r, out_i  output  DATA_W each  natural-order sample data.
REQ-010 The block SHALL have port out_ready  input  1  downstream accepts; transfer iff out_valid && out_ready.
REQ-011 The block SHALL have port frame_err  output  1  one-cycle pulse on an early in_sop that aborts a partial frame.

Function
REQ-012 The block SHALL hold two 32-entry banks (real+imag), a write-bank pointer wb, a read-bank pointer rb, per-bank full flags, a 5-bit write count wcnt and a 5-bit read count rcnt.
REQ-013 An accepted sample with write count k SHALL be stored at address bitrev5(k) of bank wb (k=1 -> 16, k=2 -> 8, k=31 -> 31).
REQ-014 An accepted sample with in_sop=1 SHALL be written at address 0 and set wcnt to 1, regardless of the prior wcnt.
REQ-015 If in_sop is accepted while wcnt != 0, the partial frame SHALL be discarded and frame_err SHALL pulse high for the following cycle.
REQ-016 An accepted sample with in_sop=0 while wcnt=0 and no frame is open SHALL be ignored (not written, wcnt unchanged).
REQ-017 On the accepted sample with wcnt=31, the block SHALL set full[wb], toggle wb and set wcnt to 0, all at the same edge.
REQ-018 in_ready SHALL equal !full[wb] from registered state, with no combinational path from out_ready.
REQ-019 out_valid SHALL equal full[rb]; out_r/out_i SHALL equal bank rb at address rcnt; out_sop = (rcnt==0); out_eop = (rcnt==31).
REQ-020 Each transfer SHALL increment rcnt; the transfer at rcnt=31 SHALL clear full[rb], toggle rb and wrap rcnt to 0.
REQ-021 Latency SHALL be exactly 1 cycle from acceptance of the 32nd input sample to out_valid=1 with out_sop=1 and natural index 0, given an empty read bank.
REQ-022 out_r/out_i/out_sop/out_eop SHALL remain stable while out_valid && !out_ready.
REQ-023 Writing one bank and draining the other in the same cycle SHALL both proceed; a bank released at an edge SHALL raise in_ready from the next cycle.
REQ-024 With both banks full, in_ready SHALL be 0 and all offered samples SHALL be dropped without corrupting stored data.

Reset
REQ-025 While rst_n=1, at the clock edge: full flags=0, wb=rb=0, wcnt=rcnt=0, in_ready=1, out_valid=out_sop=out_eop=0, frame_err=0, out_r=out_i=0; bank contents need not be cleared.
REQ-026 Reset asserted mid-frame or mid-drain SHALL abandon both frames; the first sample after reset SHALL require in_sop.

Configuration
REQ-027 When macro FFT_REORDER_DROP_CNT_EN is defined, the block SHALL add output drop_cnt (8 bits): it increments on each in_valid && !in_ready cycle, saturates at 255 and resets to 0.
REQ-028 Without FFT_REORDER_DROP_CNT_EN, the drop_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-029 Bench SHALL cover this case: one frame with in_r=k at bit-reversed position k and out_ready=1 -> out_r = 0,1,...,31 in natural order; out_sop on 0, out_eop on 31; out_valid 1 cycle after the last input.
REQ-030 Bench SHALL cover this case: three back-to-back frames with out_ready=0 -> in_ready falls after the second frame; the third frame's samples are dropped (drop_cnt=32 with the macro); releasing out_ready outputs frames 1 then 2 intact.
REQ-031 Bench SHALL cover this case: in_sop at wcnt=10, then a full frame -> frame_err pulses once; output is only the complete frame.
REQ-032 Bench SHALL cover this case: out_ready toggled 1/0 every cycle during a drain -> 32 transfers in 63 cycles; data held stable while stalled.
REQ-033 Bench SHALL cover this case: rst_n pulsed at rcnt=12 with the second bank full -> out_valid=0 next cycle; in_ready=1; the next frame outputs correctly.
REQ-034 Bench SHALL cover this case: simultaneous drain of bank 0 and fill of bank 1 at full rate -> continuous out_valid across the frame boundary with no data loss.
